fft_input_reorder: RTL



---
 rtl/fft_reorder_pkg.sv | 22 ++
 rtl/fft_input_reorder_if.sv | 44 ++++
 rtl/fft_sample_bank.sv | 30 +++
 rtl/fft_input_reorder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_reorder_pkg.sv
// Shared constants, bit-reversal helper and read-side FSM state for the FFT input reorder stage.
package fft_reorder_pkg;

    localparam int N     = 8;
    localparam int LOG2N = 3;
    localparam int DW    = 12;

    typedef enum logic [0:0] {
        IDLE,
        STREAM
    } rd_state_e;

    // Mirror the index bits: bit i of the result is bit LOG2N-1-i of the input.
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
        logic [LOG2N-1:0] rev;
        for (int i = 0; i < LOG2N; i++) begin
            rev[i] = idx[LOG2N-1-i];
        end
        return rev;
    endfunction

endpackage

// File: rtl/fft_input_reorder_if.sv
// Sample-in / operand-pair-out bus of fft_input_reorder.
// drop_cnt exists only when FFT_REORDER_DROP_CNT_EN is defined.
interface fft_input_reorder_if import fft_reorder_pkg::*; #(
    parameter int DW    = fft_reorder_pkg::DW,
    parameter int LOG2N = fft_reorder_pkg::LOG2N
);

    logic             in_valid;
    logic [DW-1:0]    in_data;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_m_real;
    logic [DW-1:0]    out_m_img;
    logic [DW-1:0]    out_n_real;
    logic [DW-1:0]    out_n_img;
    logic [LOG2N-2:0] out_pair;
    logic             out_last;
    logic             overrun;
    logic             overrun_clr;
`ifdef FFT_REORDER_DROP_CNT_EN
    logic [7:0]       drop_cnt;
`endif

    // Environment side: sample source plus operand consumer.
    modport master (
        output in_valid, in_data, out_ready, overrun_clr,
        input  out_valid, out_m_real, out_m_img, out_n_real, out_n_img,
               out_pair, out_last, overrun
`ifdef FFT_REORDER_DROP_CNT_EN
        , input drop_cnt
`endif
    );

    // Reorder block side.
    modport slave (
        input  in_valid, in_data, out_ready, overrun_clr,
        output out_valid, out_m_real, out_m_img, out_n_real, out_n_img,
               out_pair, out_last, overrun
`ifdef FFT_REORDER_DROP_CNT_EN
        , output drop_cnt
`endif
    );

endinterface

// File: rtl/fft_sample_bank.sv
// One N x DW sample bank: a single write port and two combinational read ports.
module fft_sample_bank import fft_reorder_pkg::*; #(
    parameter int N     = fft_reorder_pkg::N,
    parameter int LOG2N = fft_reorder_pkg::LOG2N,
    parameter int DW    = fft_reorder_pkg::DW
) (
    input  logic             clk,
    input  logic             we,
    input  logic [LOG2N-1:0] wr_addr,
    input  logic [DW-1:0]    wr_data,
    input  logic [LOG2N-1:0] addr_a,
    input  logic [LOG2N-1:0] addr_b,
    output logic [DW-1:0]    data_a,
    output logic [DW-1:0]    data_b
);

    logic [DW-1:0] mem [N];

    // NOTE: storage has no reset; the owner's full flags decide whether contents are meaningful.
    // NOTE: sequential state is assigned with <= so every reader sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign data_a = mem[addr_a];
    assign data_b = mem[addr_b];

endmodule

// File: rtl/fft_input_reorder.sv
// Ping-pong reorder stage feeding the first radix-2 butterfly of the 8-point FFT.
// Define FFT_REORDER_DROP_CNT_EN to add a saturating count of dropped samples on bus.drop_cnt.
module fft_input_reorder import fft_reorder_pkg::*; #(
    parameter int N     = fft_reorder_pkg::N,
    parameter int LOG2N = fft_reorder_pkg::LOG2N,
    parameter int DW    = fft_reorder_pkg::DW
) (
    input  logic               clk,
    input  logic               rst_n,
    fft_input_reorder_if.slave bus
);

    localparam int PW = LOG2N - 1;

    logic [1:0]       bank_full;
    logic [1:0]       bank_full_nxt;
    logic             wr_bank;
    logic [LOG2N-1:0] wr_addr;
    logic             handshake;
    logic             frame_done;
    logic             wr_open;
    logic             wr_accept;
    logic             wr_wrap;
    logic             drop;

    rd_state_e        state;
    rd_state_e        state_nxt;
    logic             rd_bank;
    logic             rd_bank_nxt;
    logic             out_valid_q;
    logic             out_valid_nxt;
    logic             out_last_q;
    logic             out_last_nxt;
    logic [PW-1:0]    out_pair_q;
    logic [DW-1:0]    out_m_q;
    logic [DW-1:0]    out_n_q;
    logic             overrun_q;

    logic             load;
    logic             load_bank;
    logic [PW-1:0]    load_pair;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic [DW-1:0]    data_a [2];
    logic [DW-1:0]    data_b [2];

    assign handshake  = out_valid_q & bus.out_ready;
    assign frame_done = handshake & out_last_q;

    // A bank being released by the reader this cycle is already writable.
    assign wr_open   = ~bank_full[wr_bank] | (frame_done & (rd_bank == wr_bank));
    assign wr_accept = bus.in_valid & wr_open;
    assign drop      = bus.in_valid & ~wr_open;
    assign wr_wrap   = wr_accept & (wr_addr == LOG2N'(N - 1));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_sample_bank #(
            .N     (N),
            .LOG2N (LOG2N),
            .DW    (DW)
        ) u_bank (
            .clk     (clk),
            .we      (wr_accept && (wr_bank == 1'(b))),
            .wr_addr (wr_addr),
            .wr_data (bus.in_data),
            .addr_a  (addr_a),
            .addr_b  (addr_b),
            .data_a  (data_a[b]),
            .data_b  (data_b[b])
        );
    end

    always_comb begin
        bank_full_nxt = bank_full;
        if (frame_done) begin
            bank_full_nxt[rd_bank] = 1'b0;
        end
        if (wr_wrap) begin
            bank_full_nxt[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full <= 2'b00;
            wr_bank   <= 1'b0;
            wr_addr   <= '0;
        end else begin
            bank_full <= bank_full_nxt;
            if (wr_accept) begin
                wr_addr <= wr_addr + 1'b1;
                if (wr_wrap) begin
                    wr_bank <= ~wr_bank;
                end
            end
        end
    end

    // Pair p pulls x_m from bitrev(2p) and x_n from bitrev(2p+1).
    assign addr_a = bitrev({load_pair, 1'b0});
    assign addr_b = bitrev({load_pair, 1'b1});

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt     = state;
        rd_bank_nxt   = rd_bank;
        out_valid_nxt = out_valid_q;
        out_last_nxt  = out_last_q;
        load          = 1'b0;
        load_bank     = rd_bank;
        load_pair     = '0;

        case (state)
            IDLE: begin
                if (bank_full[rd_bank]) begin
                    load          = 1'b1;
                    out_valid_nxt = 1'b1;
                    state_nxt     = STREAM;
                end
            end
            STREAM: begin
                if (handshake) begin
                    if (out_last_q) begin
                        rd_bank_nxt = ~rd_bank;
                        if (bank_full[~rd_bank]) begin
                            load      = 1'b1;
                            load_bank = ~rd_bank;
                        end else begin
                            out_valid_nxt = 1'b0;
                            out_last_nxt  = 1'b0;
                            state_nxt     = IDLE;
                        end
                    end else begin
                        load      = 1'b1;
                        load_pair = out_pair_q + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (load) begin
            out_last_nxt = (load_pair == '1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rd_bank     <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_pair_q  <= '0;
            out_m_q     <= '0;
            out_n_q     <= '0;
        end else begin
            state       <= state_nxt;
            rd_bank     <= rd_bank_nxt;
            out_valid_q <= out_valid_nxt;
            out_last_q  <= out_last_nxt;
            if (load) begin
                out_pair_q <= load_pair;
                out_m_q    <= data_a[load_bank];
                out_n_q    <= data_b[load_bank];
            end
        end
    end

    // Set wins over clear when a drop coincides with overrun_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end else if (bus.overrun_clr) begin
            overrun_q <= 1'b0;
        end
    end

`ifdef FFT_REORDER_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (bus.overrun_clr) begin
            drop_cnt_q <= {7'd0, drop};
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`endif

    assign bus.out_valid  = out_valid_q;
    assign bus.out_m_real = out_m_q;
    assign bus.out_m_img  = '0;
    assign bus.out_n_real = out_n_q;
    assign bus.out_n_img  = '0;
    assign bus.out_pair   = out_pair_q;
    assign bus.out_last   = out_last_q;
    assign bus.overrun    = overrun_q;

endmodule
